// File: rtl/i2s_codec_if.sv
// I2S master for the WM8731: derives BCLK/LRCLK from clk, serialises stereo DAC
// samples onto DACDAT and deserialises ADCDAT into stereo samples (Philips format).
module i2s_codec_if #(
  parameter int BCLK_DIV     = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] tx_left,
  input  logic [SAMPLE_WIDTH-1:0] tx_right,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    tx_underrun,
  output logic [SAMPLE_WIDTH-1:0] rx_left,
  output logic [SAMPLE_WIDTH-1:0] rx_right,
  output logic                    rx_valid,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_dacdat,
  input  logic                    i2s_adcdat
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
  localparam int IDX_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] SW_C     = CNT_W'(SAMPLE_WIDTH);

  logic [DIV_W-1:0]        r_div_cnt;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic                    r_bclk;
  logic                    r_lrclk;
  logic                    r_dacdat;
  logic                    r_hold_full;
  logic [SAMPLE_WIDTH-1:0] r_hold_l;
  logic [SAMPLE_WIDTH-1:0] r_hold_r;
  logic [SAMPLE_WIDTH-1:0] r_tx_l;
  logic [SAMPLE_WIDTH-1:0] r_tx_r;
  logic [SAMPLE_WIDTH-1:0] r_rx_sh_l;
  logic [SAMPLE_WIDTH-1:0] r_rx_sh_r;
  logic [SAMPLE_WIDTH-1:0] r_rx_l;
  logic [SAMPLE_WIDTH-1:0] r_rx_r;
  logic                    r_rx_done;
  logic                    r_rx_valid;
  logic                    r_underrun;

  logic             w_tc;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_k;
  logic             w_k_right;
  logic [CNT_W-1:0] w_k_pos;
  logic             w_frame_start;
  logic             w_cur_right;
  logic [CNT_W-1:0] w_cur_pos;
  logic             w_cur_data;
  logic [IDX_W-1:0] w_tx_idx;
  logic             w_dac_bit;

  assign w_tc          = (r_div_cnt == DIV_LAST);
  assign w_rise        = enable && w_tc && !r_bclk;
  assign w_fall        = enable && w_tc && r_bclk;
  assign w_k           = (r_bit_cnt == CNT_LAST) ? '0 : r_bit_cnt + 1'b1;
  assign w_k_right     = (w_k >= SLOT_C);
  assign w_k_pos       = w_k_right ? w_k - SLOT_C : w_k;
  assign w_frame_start = w_fall && (w_k == '0);
  assign w_cur_right   = (r_bit_cnt >= SLOT_C);
  assign w_cur_pos     = w_cur_right ? r_bit_cnt - SLOT_C : r_bit_cnt;
  assign w_cur_data    = (w_cur_pos != '0) && (w_cur_pos <= SW_C);
  assign w_tx_idx      = IDX_W'(SW_C - w_k_pos);

  // Slot position 1 carries the MSB; position 0 and the tail of the slot stay 0.
  always_comb begin
    w_dac_bit = 1'b0;
    if ((w_k_pos != '0) && (w_k_pos <= SW_C)) begin
      w_dac_bit = w_k_right ? r_tx_r[w_tx_idx] : r_tx_l[w_tx_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= CNT_LAST;
      r_bclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_dacdat    <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_tx_l      <= '0;
      r_tx_r      <= '0;
      r_rx_sh_l   <= '0;
      r_rx_sh_r   <= '0;
      r_rx_l      <= '0;
      r_rx_r      <= '0;
      r_rx_done   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_rx_done  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      if (r_rx_done) begin
        r_rx_l     <= r_rx_sh_l;
        r_rx_r     <= r_rx_sh_r;
        r_rx_valid <= 1'b1;
      end

      // A pair accepted in the frame-start clk lands after the load, so it waits a frame.
      if (tx_valid && !r_hold_full) begin
        r_hold_l    <= tx_left;
        r_hold_r    <= tx_right;
        r_hold_full <= 1'b1;
      end else if (w_frame_start) begin
        r_hold_full <= 1'b0;
      end

      if (!enable) begin
        r_div_cnt <= '0;
        r_bit_cnt <= CNT_LAST;
        r_bclk    <= 1'b0;
        r_lrclk   <= 1'b0;
        r_dacdat  <= 1'b0;
      end else begin
        r_div_cnt <= w_tc ? '0 : r_div_cnt + 1'b1;
        if (w_tc) begin
          r_bclk <= ~r_bclk;
        end
        if (w_fall) begin
          r_bit_cnt <= w_k;
          r_lrclk   <= w_k_right;
          r_dacdat  <= w_dac_bit;
        end
        if (w_frame_start) begin
          r_tx_l     <= r_hold_full ? r_hold_l : '0;
          r_tx_r     <= r_hold_full ? r_hold_r : '0;
          r_underrun <= !r_hold_full;
        end
        if (w_rise && w_cur_data) begin
          if (w_cur_right) begin
            r_rx_sh_r <= SAMPLE_WIDTH'({r_rx_sh_r, i2s_adcdat});
          end else begin
            r_rx_sh_l <= SAMPLE_WIDTH'({r_rx_sh_l, i2s_adcdat});
          end
          if (w_cur_right && (w_cur_pos == SW_C)) begin
            r_rx_done <= 1'b1;
          end
        end
      end
    end
  end

  assign tx_ready    = !r_hold_full;
  assign tx_underrun = r_underrun;
  assign rx_left     = r_rx_l;
  assign rx_right    = r_rx_r;
  assign rx_valid    = r_rx_valid;
  assign i2s_bclk    = r_bclk;
  assign i2s_lrclk   = r_lrclk;
  assign i2s_dacdat  = r_dacdat;

endmodule

// File: tb/tb_i2s_codec_if.sv
// Directed bench for i2s_codec_if: default 16/32 configuration plus a
// BCLK_DIV=1, 24-bit instance; expected values are hand-derived per scenario.
module tb_i2s_codec_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: default parameters
  logic        a_rst = 1'b1, a_en = 1'b0, a_txv = 1'b0, a_loop = 1'b0, a_adc_drv = 1'b0;
  logic [15:0] a_txl = '0, a_txr = '0;
  logic        a_rdy, a_und, a_rxv, a_bclk, a_lrclk, a_dac, a_adc;
  logic [15:0] a_rxl, a_rxr;
  assign a_adc = a_loop ? a_dac : a_adc_drv;

  i2s_codec_if u_a (
    .clk(clk), .rst(a_rst), .enable(a_en),
    .tx_left(a_txl), .tx_right(a_txr), .tx_valid(a_txv),
    .tx_ready(a_rdy), .tx_underrun(a_und),
    .rx_left(a_rxl), .rx_right(a_rxr), .rx_valid(a_rxv),
    .i2s_bclk(a_bclk), .i2s_lrclk(a_lrclk), .i2s_dacdat(a_dac), .i2s_adcdat(a_adc)
  );

  // Instance B: fast bit clock, 24-bit samples
  logic        b_rst = 1'b1, b_en = 1'b0, b_txv = 1'b0;
  logic [23:0] b_txl = '0, b_txr = '0;
  logic        b_rdy, b_und, b_rxv, b_bclk, b_lrclk, b_dac;
  logic [23:0] b_rxl, b_rxr;

  i2s_codec_if #(.BCLK_DIV(1), .SAMPLE_WIDTH(24), .SLOT_WIDTH(32)) u_b (
    .clk(clk), .rst(b_rst), .enable(b_en),
    .tx_left(b_txl), .tx_right(b_txr), .tx_valid(b_txv),
    .tx_ready(b_rdy), .tx_underrun(b_und),
    .rx_left(b_rxl), .rx_right(b_rxr), .rx_valid(b_rxv),
    .i2s_bclk(b_bclk), .i2s_lrclk(b_lrclk), .i2s_dacdat(b_dac), .i2s_adcdat(b_dac)
  );

  // Capture state filled by capture_a: dacdat at each bclk rise since enable
  logic        cap_bits [0:255];
  int          cap_rxv, cap_und;
  logic [15:0] cap_rxl, cap_rxr;

  task automatic reset_a();
    @(negedge clk);
    a_rst = 1'b1; a_en = 1'b0; a_txv = 1'b0; a_loop = 1'b0; a_adc_drv = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
  endtask

  // Rise index 0 is the rise before the first frame start; rise r>=1 sees bit_cnt r-1.
  task automatic capture_a(input int nrises);
    int   r = 0;
    int   guard = 0;
    logic prev = a_bclk;
    cap_rxv = 0; cap_und = 0;
    while (r < nrises && guard < nrises * 8 + 16) begin
      @(negedge clk);
      guard++;
      if (a_rxv) begin cap_rxv++; cap_rxl = a_rxl; cap_rxr = a_rxr; end
      if (a_und) cap_und++;
      if (a_bclk && !prev) begin cap_bits[r] = a_dac; r++; end
      prev = a_bclk;
    end
    n_cmp++;
    if (r != nrises) begin
      n_bad++; $display("FAIL capture_bound rises=%0d required=%0d", r, nrises);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp += 8;
    if (a_bclk !== 1'b0)   begin n_bad++; $display("FAIL rst_bclk got=%b want=0", a_bclk); end
    if (a_lrclk !== 1'b0)  begin n_bad++; $display("FAIL rst_lrclk got=%b want=0", a_lrclk); end
    if (a_dac !== 1'b0)    begin n_bad++; $display("FAIL rst_dacdat got=%b want=0", a_dac); end
    if (a_rdy !== 1'b1)    begin n_bad++; $display("FAIL rst_tx_ready got=%b want=1", a_rdy); end
    if (a_und !== 1'b0)    begin n_bad++; $display("FAIL rst_underrun got=%b want=0", a_und); end
    if (a_rxv !== 1'b0)    begin n_bad++; $display("FAIL rst_rx_valid got=%b want=0", a_rxv); end
    if (a_rxl !== 16'h0)   begin n_bad++; $display("FAIL rst_rx_left got=%h want=0", a_rxl); end
    if (a_rxr !== 16'h0)   begin n_bad++; $display("FAIL rst_rx_right got=%h want=0", a_rxr); end
    $display("test_reset done");
  endtask

  task automatic test_clocks();
    int br0 = -1, br1 = -1, bf0 = -1, lr0 = -1, lr1 = -1, lf0 = -1;
    logic pb, pl;
    reset_a();
    a_en = 1'b1;
    pb = a_bclk; pl = a_lrclk;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (a_bclk && !pb) begin if (br0 < 0) br0 = c; else if (br1 < 0) br1 = c; end
      if (!a_bclk && pb && bf0 < 0) bf0 = c;
      if (a_lrclk && !pl) begin if (lr0 < 0) lr0 = c; else if (lr1 < 0) lr1 = c; end
      if (!a_lrclk && pl && lf0 < 0) lf0 = c;
      pb = a_bclk; pl = a_lrclk;
    end
    n_cmp += 5;
    if (br1 - br0 != 4)   begin n_bad++; $display("FAIL bclk_period got=%0d want=4", br1 - br0); end
    if (bf0 - br0 != 2)   begin n_bad++; $display("FAIL bclk_high got=%0d want=2", bf0 - br0); end
    if (lr0 != 132)       begin n_bad++; $display("FAIL lrclk_first_rise got=%0d want=132", lr0); end
    if (lf0 - lr0 != 128) begin n_bad++; $display("FAIL lrclk_high got=%0d want=128", lf0 - lr0); end
    if (lr1 - lr0 != 256) begin n_bad++; $display("FAIL lrclk_period got=%0d want=256", lr1 - lr0); end
    a_en = 1'b0;
    $display("test_clocks done");
  endtask

  task automatic test_tx_serial();
    logic [15:0] lv = 16'hA5C3, rv = 16'h8001, s;
    int k, p;
    logic exp;
    reset_a();
    a_txl = lv; a_txr = rv; a_txv = 1'b1;
    @(negedge clk);
    a_txv = 1'b0;
    n_cmp++;
    if (a_rdy !== 1'b0) begin n_bad++; $display("FAIL tx_ready_drop got=%b want=0", a_rdy); end
    a_en = 1'b1;
    capture_a(65);
    for (int r = 0; r < 65; r++) begin
      exp = 1'b0;
      if (r >= 1) begin
        k = r - 1; p = k % 32; s = (k >= 32) ? rv : lv;
        if (p >= 1 && p <= 16) exp = s[16 - p];
      end
      n_cmp++;
      if (cap_bits[r] !== exp) begin
        n_bad++; $display("FAIL dacdat_rise%0d got=%b want=%b", r, cap_bits[r], exp);
      end
    end
    n_cmp += 2;
    if (cap_und != 0)   begin n_bad++; $display("FAIL tx_underrun_loaded got=%0d want=0", cap_und); end
    if (a_rdy !== 1'b1) begin n_bad++; $display("FAIL tx_ready_after_load got=%b want=1", a_rdy); end
    a_en = 1'b0;
    $display("test_tx_serial done");
  endtask

  task automatic test_loopback();
    reset_a();
    a_loop = 1'b1; a_txl = 16'h1234; a_txr = 16'hFEDC; a_txv = 1'b1; a_en = 1'b1;
    capture_a(130);
    n_cmp += 4;
    if (cap_rxv != 2)          begin n_bad++; $display("FAIL loop_rx_valid_count got=%0d want=2", cap_rxv); end
    if (cap_rxl !== 16'h1234)  begin n_bad++; $display("FAIL loop_rx_left got=%h want=1234", cap_rxl); end
    if (cap_rxr !== 16'hFEDC)  begin n_bad++; $display("FAIL loop_rx_right got=%h want=fedc", cap_rxr); end
    if (cap_und != 0)          begin n_bad++; $display("FAIL loop_underrun got=%0d want=0", cap_und); end
    a_txv = 1'b0; a_en = 1'b0;
    $display("test_loopback done");
  endtask

  task automatic test_underrun();
    int ones = 0;
    reset_a();
    a_en = 1'b1;
    capture_a(128);
    for (int r = 0; r < 128; r++) if (cap_bits[r] === 1'b1) ones++;
    n_cmp += 2;
    if (cap_und != 2) begin n_bad++; $display("FAIL underrun_count got=%0d want=2", cap_und); end
    if (ones != 0)    begin n_bad++; $display("FAIL underrun_dacdat_ones got=%0d want=0", ones); end
    a_en = 1'b0;
    $display("test_underrun done");
  endtask

  task automatic test_disable();
    int busy = 0;
    reset_a();
    a_loop = 1'b1; a_txl = 16'hA5C3; a_txr = 16'h8001; a_txv = 1'b1; a_en = 1'b1;
    capture_a(41);
    a_en = 1'b0;
    n_cmp++;
    if (cap_rxv != 0) begin n_bad++; $display("FAIL dis_partial_rx_valid got=%0d want=0", cap_rxv); end
    @(negedge clk);
    n_cmp += 3;
    if (a_bclk !== 1'b0)  begin n_bad++; $display("FAIL dis_bclk got=%b want=0", a_bclk); end
    if (a_lrclk !== 1'b0) begin n_bad++; $display("FAIL dis_lrclk got=%b want=0", a_lrclk); end
    if (a_dac !== 1'b0)   begin n_bad++; $display("FAIL dis_dacdat got=%b want=0", a_dac); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_bclk || a_lrclk || a_rxv) busy++;
    end
    n_cmp += 2;
    if (busy != 0)       begin n_bad++; $display("FAIL dis_idle_activity got=%0d want=0", busy); end
    if (a_rxl !== 16'h0) begin n_bad++; $display("FAIL dis_rx_left_kept got=%h want=0", a_rxl); end
    a_en = 1'b1;
    capture_a(51);
    n_cmp += 5;
    if (cap_bits[1] !== 1'b0) begin n_bad++; $display("FAIL reen_slot_pos0 got=%b want=0", cap_bits[1]); end
    if (cap_bits[2] !== 1'b1) begin n_bad++; $display("FAIL reen_msb got=%b want=1", cap_bits[2]); end
    if (cap_rxv != 1)         begin n_bad++; $display("FAIL reen_rx_valid got=%0d want=1", cap_rxv); end
    if (cap_rxl !== 16'hA5C3) begin n_bad++; $display("FAIL reen_rx_left got=%h want=a5c3", cap_rxl); end
    if (cap_rxr !== 16'h8001) begin n_bad++; $display("FAIL reen_rx_right got=%h want=8001", cap_rxr); end
    a_txv = 1'b0; a_en = 1'b0;
    $display("test_disable done");
  endtask

  task automatic test_wide_fast();
    int seen = 0;
    logic [23:0] gl = '0, gr = '0;
    @(negedge clk);
    b_rst = 1'b0;
    b_txl = 24'h800001; b_txr = 24'h7FFFFE; b_txv = 1'b1; b_en = 1'b1;
    for (int c = 0; c < 300 && seen == 0; c++) begin
      @(negedge clk);
      if (b_rxv) begin seen = 1; gl = b_rxl; gr = b_rxr; end
    end
    n_cmp += 3;
    if (seen != 1)          begin n_bad++; $display("FAIL w24_rx_valid got=%0d want=1", seen); end
    if (gl !== 24'h800001)  begin n_bad++; $display("FAIL w24_rx_left got=%h want=800001", gl); end
    if (gr !== 24'h7FFFFE)  begin n_bad++; $display("FAIL w24_rx_right got=%h want=7ffffe", gr); end
    repeat (21) @(negedge clk);
    b_txv = 1'b0; b_rst = 1'b1;
    @(negedge clk);
    n_cmp += 8;
    if (b_bclk !== 1'b0)   begin n_bad++; $display("FAIL w24_rst_bclk got=%b want=0", b_bclk); end
    if (b_lrclk !== 1'b0)  begin n_bad++; $display("FAIL w24_rst_lrclk got=%b want=0", b_lrclk); end
    if (b_dac !== 1'b0)    begin n_bad++; $display("FAIL w24_rst_dacdat got=%b want=0", b_dac); end
    if (b_rdy !== 1'b1)    begin n_bad++; $display("FAIL w24_rst_tx_ready got=%b want=1", b_rdy); end
    if (b_und !== 1'b0)    begin n_bad++; $display("FAIL w24_rst_underrun got=%b want=0", b_und); end
    if (b_rxv !== 1'b0)    begin n_bad++; $display("FAIL w24_rst_rx_valid got=%b want=0", b_rxv); end
    if (b_rxl !== 24'h0)   begin n_bad++; $display("FAIL w24_rst_rx_left got=%h want=0", b_rxl); end
    if (b_rxr !== 24'h0)   begin n_bad++; $display("FAIL w24_rst_rx_right got=%h want=0", b_rxr); end
    b_en = 1'b0;
    $display("test_wide_fast done");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    a_rst = 1'b0;
    test_clocks();
    test_tx_serial();
    test_loopback();
    test_underrun();
    test_disable();
    test_wide_fast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout time=%0t limit=1000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
